noc_sw_alloc: RTL and testbench
===============================

# noc_sw_alloc

Switch allocator for the 5-port mesh router. It takes per-input routing requests (one-hot N/E/W/S/L from each input's LBDR stage) and grants each output port to at most one input at a time, using per-output round-robin arbitration. A grant is held from HEADER through TAIL so packets are never interleaved. It drives crossbar selects, input-FIFO read enables and output valid strobes, and respects downstream backpressure.

## Interface
Parameters:
- NPORTS, 5, number of router ports; index 0=N, 1=E, 2=W, 3=S, 4=L.
- FIDW, 3, flit_id width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  NPORTS  input FIFO i non-empty (~empty)
- in_flit_id  in  NPORTS*FIDW  flit_id of the head flit of input i, slice [i*FIDW +: FIDW]
- in_req  in  NPORTS*NPORTS  one-hot requested output of input i, slice [i*5 +: 5], bit order {L,S,W,E,N} = [4:0]
- out_ready  in  NPORTS  downstream of output o can accept a flit
- in_rd_en  out  NPORTS  pop input FIFO i this cycle
- out_valid  out  NPORTS  flit presented on output o this cycle
- out_sel  out  NPORTS*3  crossbar select for output o (input index 0..4), slice [o*3 +: 3]
- out_busy  out  NPORTS  output o is locked to a packet
- err  out  1  one-cycle pulse on an illegal request

## Operation
- Per output o: FSM {IDLE, BUSY}, a 3-bit owner register and a 3-bit round-robin pointer ptr[o].
- Candidates for o in IDLE: input i with in_valid[i], in_flit_id[i]==`HEADER, in_req[i][o]=1, input i not owned by any output, and a legal request.
- Illegal request: in_req[i] not one-hot, or a U-turn (i==o, i≠L). This pulses err the next cycle, and the request is ignored.
- Arbitration: first candidate searching ptr[o], ptr[o]+1, … mod 5. The winner is registered as owner, and the FSM goes to BUSY.
- BUSY transfer condition: in_valid[owner] & out_ready[o]. When it holds, in_rd_en[owner]=1 and out_valid[o]=1, both combinational from registered state and current valid/ready.
- Any stall holds state and owner. A stall is in_valid low (FIFO empty mid-packet) or out_ready low.
- Transfer of a flit with flit_id==`TAIL: at the next edge the FSM returns to IDLE and ptr[o] becomes owner+1 (4 wraps to 0).
- in_rd_en[i] is the OR over all outputs owned by i. At most one output owns an input.
- out_sel[o]=owner while BUSY, 0 while IDLE. out_busy[o]=(state==BUSY).
- Reset values: all FSMs IDLE, owner=0, ptr=0, out_sel=0, out_busy=0, in_rd_en=0, out_valid=0, err=0. Reset mid-packet abandons the packet with no flush.

## Timing
- HEADER plus request visible in cycle t → owner registered at edge t+1 → first transfer (the HEADER) possible in cycle t+1.
- One flit per output per cycle. An n-flit packet with no stalls occupies cycles t+1..t+n.
- TAIL transferred in cycle k → IDLE in cycle k+1, arbitration in k+1 → next packet's HEADER transferred at k+2 earliest. This one-cycle bubble per packet is required.
- All 5 outputs arbitrate independently in the same cycle. Distinct outputs can serve distinct inputs concurrently.
- An in_req change while not granted is simply re-sampled. in_req is ignored while the input is owned.
- err is registered: illegal request in cycle t → err=1 in cycle t+1 only.

## Structure
- noc_pkg: NPORTS, port index constants (P_N..P_L), alloc_state_t {IDLE, BUSY}, flit_id constants mirroring `HEADER/`PAYLOAD/`TAIL from the shared parameters include.
- Sub-module rr_arb5: 5-bit request vector plus 3-bit pointer in, one-hot grant plus 3-bit index out. Purely combinational, instantiated once per output.
- Top: 5 FSM/owner/pointer slices, an input-ownership vector and the err register.

## Test plan
- L(4) requests E with a 4-flit packet (H,P,P,T), out_ready=1 → out_busy[E]=1 and out_sel[E]=4 from cycle 1; in_rd_en[4]/out_valid[E] high cycles 1–4; IDLE cycle 5; ptr[E]=0.
- N(0) and W(2) both request S with HEADER at cycle 0, ptr[S]=0 → N granted cycle 1; after N's TAIL at cycle k, W's HEADER transfers at k+2; final ptr[S]=3 after W's TAIL.
- Backpressure: out_ready[E]=0 for 3 cycles mid-packet → in_rd_en/out_valid low for exactly those cycles, owner unchanged, packet completes intact.
- Empty mid-packet: in_valid[owner]=0 for 2 cycles → no transfer, out_busy stays 1, no other input granted.
- Illegal: in_req[1]=5'b00011 (multi-hot), or E input requesting E → err=1 next cycle, no grant, out_busy unchanged.
- Reset asserted while S is BUSY → next cycle all outputs 0, ptrs 0; a fresh HEADER after reset is granted normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router constants, port indices, flit_id encodings and the allocator state type.
package noc_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned FIDW   = 3;

    localparam int unsigned P_N = 0;
    localparam int unsigned P_E = 1;
    localparam int unsigned P_W = 2;
    localparam int unsigned P_S = 3;
    localparam int unsigned P_L = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } alloc_state_t;

    // Mirrors `HEADER/`PAYLOAD/`TAIL from the shared parameters include.
    localparam logic [FIDW-1:0] FLIT_HEADER  = 3'b001;
    localparam logic [FIDW-1:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [FIDW-1:0] FLIT_TAIL    = 3'b100;

    function automatic logic [2:0] ptr_after(input logic [2:0] owner);
        return (owner >= 3'(NPORTS - 1)) ? 3'd0 : owner + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-way round-robin arbiter: the first request found searching from ptr_i upward,
// wrapping modulo 5, wins.
module rr_arb5 (
    input  logic [4:0] req_i,
    input  logic [2:0] ptr_i,
    output logic [4:0] gnt_o,
    output logic [2:0] idx_o
);

    logic [2:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            j = 3'((32'(ptr_i) + k) % 5);
            if (gnt_o == '0 && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/noc_sw_alloc.sv
// Switch allocator: each output grants one input per packet (HEADER..TAIL) with round-robin
// fairness, and drives crossbar selects, input FIFO pops and output strobes.
module noc_sw_alloc #(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned FIDW   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic [NPORTS*FIDW-1:0]   in_flit_id,
    input  logic [NPORTS*NPORTS-1:0] in_req,
    input  logic [NPORTS-1:0]        out_ready,
    output logic [NPORTS-1:0]        in_rd_en,
    output logic [NPORTS-1:0]        out_valid,
    output logic [NPORTS*3-1:0]      out_sel,
    output logic [NPORTS-1:0]        out_busy,
    output logic                     err
);

    import noc_pkg::*;

    alloc_state_t      state_q [NPORTS];
    alloc_state_t      state_d [NPORTS];
    logic [2:0]        owner_q [NPORTS];
    logic [2:0]        owner_d [NPORTS];
    logic [2:0]        ptr_q   [NPORTS];
    logic [2:0]        ptr_d   [NPORTS];
    logic              err_q;
    logic              err_d;

    logic [NPORTS-1:0] req     [NPORTS];
    logic [FIDW-1:0]   fid     [NPORTS];
    logic [NPORTS-1:0] cand    [NPORTS];  // cand[o][i]: input i competes for output o
    logic [NPORTS-1:0] gnt     [NPORTS];
    logic [2:0]        win     [NPORTS];
    logic [NPORTS-1:0] owned;
    logic [NPORTS-1:0] legal;
    logic [NPORTS-1:0] illegal;

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            req[i] = in_req[i*NPORTS +: NPORTS];
            fid[i] = in_flit_id[i*FIDW +: FIDW];
        end
    end

    always_comb begin
        owned    = '0;
        in_rd_en = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (state_q[o] == BUSY) begin
                owned[owner_q[o]] = 1'b1;
                if (in_valid[owner_q[o]] && out_ready[o]) begin
                    in_rd_en[owner_q[o]] = 1'b1;
                end
            end
        end
    end

    // Only unowned HEADERs are judged; an owned input's request lines are don't-care.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            legal[i]   = $onehot(req[i]) && !(i != int'(P_L) && req[i][i]);
            illegal[i] = in_valid[i] && (fid[i] == FLIT_HEADER) && !owned[i] && !legal[i];
            for (int o = 0; o < NPORTS; o++) begin
                cand[o][i] = in_valid[i] && (fid[i] == FLIT_HEADER) && !owned[i] && legal[i]
                             && req[i][o];
            end
        end
        err_d = |illegal;
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arb5 u_arb (
            .req_i (cand[o]),
            .ptr_i (ptr_q[o]),
            .gnt_o (gnt[o]),
            .idx_o (win[o])
        );
    end

    always_comb begin
        out_valid = '0;
        out_sel   = '0;
        out_busy  = '0;
        for (int o = 0; o < NPORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            if (state_q[o] == BUSY) begin
                out_busy[o]       = 1'b1;
                out_sel[o*3 +: 3] = owner_q[o];
                if (in_valid[owner_q[o]] && out_ready[o]) begin
                    out_valid[o] = 1'b1;
                    if (fid[owner_q[o]] == FLIT_TAIL) begin
                        state_d[o] = IDLE;
                        ptr_d[o]   = ptr_after(owner_q[o]);
                    end
                end
            end else if (|gnt[o]) begin
                state_d[o] = BUSY;
                owner_d[o] = win[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_noc_sw_alloc.sv
// Scoreboard bench for noc_sw_alloc: input FIFOs are modelled as queues, expected transfers
// and err pulses are queued by the stimulus and checked by a negedge monitor.
module tb_noc_sw_alloc;

    import noc_pkg::*;

    localparam int NP = 5;
    localparam logic [4:0] RQ_E = 5'b00010;
    localparam logic [4:0] RQ_W = 5'b00100;
    localparam logic [4:0] RQ_S = 5'b01000;
    localparam logic [4:0] RQ_L = 5'b10000;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    in_valid;
    logic [NP*3-1:0]  in_flit_id;
    logic [NP*NP-1:0] in_req;
    logic [NP-1:0]    out_ready;
    logic [NP-1:0]    in_rd_en;
    logic [NP-1:0]    out_valid;
    logic [NP*3-1:0]  out_sel;
    logic [NP-1:0]    out_busy;
    logic             err;

    typedef struct packed {
        logic [2:0] fid;
        logic [4:0] req;
    } flit_t;

    typedef struct {
        int         cyc;
        int         sel;
        logic [2:0] fid;
    } xfer_t;

    flit_t fifo  [NP][$];
    xfer_t exp_q [NP][$];
    int    err_q [$];
    int    cyc;
    int    checks;
    int    errors;
    int    c0;

    noc_sw_alloc #(
        .NPORTS (5),
        .FIDW   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit_id (in_flit_id),
        .in_req     (in_req),
        .out_ready  (out_ready),
        .in_rd_en   (in_rd_en),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .out_busy   (out_busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [NP*3-1:0] sel_of(input int o, input int s);
        logic [NP*3-1:0] v;
        v = '0;
        v[o*3 +: 3] = 3'(s);
        return v;
    endfunction

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (fifo[i].size() > 0) begin
                in_valid[i]            = 1'b1;
                in_flit_id[i*3 +: 3]   = fifo[i][0].fid;
                in_req[i*NP +: NP]     = fifo[i][0].req;
            end else begin
                in_valid[i]            = 1'b0;
                in_flit_id[i*3 +: 3]   = 3'b000;
                in_req[i*NP +: NP]     = 5'b00000;
            end
        end
    endtask

    // Drives cycle `cyc`, lets the monitor sample it, then pops what the DUT read.
    task automatic tick();
        logic [NP-1:0] rd;
        drive();
        @(negedge clk);
        rd = in_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rd[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        cyc++;
    endtask

    task automatic push_flit(input int i, input logic [2:0] f, input logic [4:0] r);
        fifo[i].push_back('{fid: f, req: r});
    endtask

    task automatic push_pkt(input int i, input logic [4:0] r, input int n);
        push_flit(i, FLIT_HEADER, r);
        for (int k = 0; k < n - 2; k++) push_flit(i, FLIT_PAYLOAD, r);
        push_flit(i, FLIT_TAIL, r);
    endtask

    task automatic expect_xfer(input int o, input int c, input int s, input logic [2:0] f);
        exp_q[o].push_back('{cyc: c, sel: s, fid: f});
    endtask

    task automatic expect_pkt(input int o, input int c, input int s, input int n);
        for (int k = 0; k < n; k++) begin
            expect_xfer(o, c + k, s, (k == 0) ? FLIT_HEADER :
                                     (k == n - 1) ? FLIT_TAIL : FLIT_PAYLOAD);
        end
    endtask

    task automatic check_regs(input string name, input logic [NP-1:0] busy,
                              input logic [NP*3-1:0] sel, input logic e);
        checks++;
        if (out_busy !== busy || out_sel !== sel || err !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got busy=%b sel=%h err=%b, required busy=%b sel=%h err=%b",
                     name, cyc, out_busy, out_sel, err, busy, sel, e);
        end
    endtask

    task automatic check_drained(input string name);
        int left;
        left = err_q.size();
        for (int o = 0; o < NP; o++) left += exp_q[o].size();
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL %s_drained cycle %0d: got %0d expected events still pending, required 0",
                     name, cyc, left);
        end
    endtask

    always @(negedge clk) begin : monitor
        int         s;
        logic [2:0] f;
        xfer_t      e;
        for (int o = 0; o < NP; o++) begin
            if (out_valid[o] === 1'b1) begin
                s = int'(out_sel[o*3 +: 3]);
                f = (s < NP) ? in_flit_id[s*3 +: 3] : 3'b000;
                checks++;
                if (exp_q[o].size() == 0) begin
                    errors++;
                    $display("FAIL xfer out%0d cycle %0d: got sel=%0d fid=%b, required no transfer",
                             o, cyc, s, f);
                end else begin
                    e = exp_q[o].pop_front();
                    if (e.cyc != cyc || e.sel != s || e.fid != f || !(s < NP && in_rd_en[s])) begin
                        errors++;
                        $display("FAIL xfer out%0d: got cycle=%0d sel=%0d fid=%b rd_en=%b, required cycle=%0d sel=%0d fid=%b rd_en=1",
                                 o, cyc, s, f, in_rd_en, e.cyc, e.sel, e.fid);
                    end
                end
            end
        end
        if (err === 1'b1) begin
            checks++;
            if (err_q.size() == 0 || err_q[0] != cyc) begin
                errors++;
                $display("FAIL err_pulse: got err=1 at cycle %0d, required pending err cycle %0d",
                         cyc, (err_q.size() == 0) ? -1 : err_q[0]);
            end
            if (err_q.size() > 0) void'(err_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        out_ready  = '1;
        in_valid   = '0;
        in_flit_id = '0;
        in_req     = '0;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        repeat (3) tick();
        rst = 1'b0;
        check_regs("reset", 5'b00000, '0, 1'b0);
        checks++;
        if (in_rd_en !== 5'b00000 || out_valid !== 5'b00000) begin
            errors++;
            $display("FAIL reset_strobes: got rd_en=%b out_valid=%b, required 00000 00000",
                     in_rd_en, out_valid);
        end

        // L sends 4 flits to E while N sends 2 flits to W concurrently.
        c0 = cyc;
        push_pkt(4, RQ_E, 4);
        push_pkt(0, RQ_W, 2);
        expect_pkt(1, c0 + 1, 4, 4);
        expect_pkt(2, c0 + 1, 0, 2);
        tick();
        check_regs("t1_grant", 5'b00110, sel_of(1, 4), 1'b0);
        repeat (4) tick();
        check_regs("t1_idle", 5'b00000, '0, 1'b0);
        check_drained("t1");

        // N and W contend for S with ptr[S]=0: N first, W after a one-cycle bubble.
        c0 = cyc;
        push_pkt(0, RQ_S, 3);
        push_pkt(2, RQ_S, 2);
        expect_pkt(3, c0 + 1, 0, 3);
        expect_pkt(3, c0 + 5, 2, 2);
        tick();
        check_regs("t2_n_first", 5'b01000, sel_of(3, 0), 1'b0);
        repeat (3) tick();
        check_regs("t2_bubble", 5'b00000, '0, 1'b0);
        tick();
        check_regs("t2_w_second", 5'b01000, sel_of(3, 2), 1'b0);
        repeat (2) tick();
        check_drained("t2");

        // ptr[S] is now 3: L beats W.
        c0 = cyc;
        push_pkt(2, RQ_S, 2);
        push_pkt(4, RQ_S, 2);
        expect_pkt(3, c0 + 1, 4, 2);
        expect_pkt(3, c0 + 4, 2, 2);
        tick();
        check_regs("t2_ptr3", 5'b01000, sel_of(3, 4), 1'b0);
        repeat (5) tick();
        check_drained("t2b");

        // Backpressure on E for three cycles mid-packet.
        c0 = cyc;
        push_pkt(4, RQ_E, 4);
        expect_xfer(1, c0 + 1, 4, FLIT_HEADER);
        expect_xfer(1, c0 + 5, 4, FLIT_PAYLOAD);
        expect_xfer(1, c0 + 6, 4, FLIT_PAYLOAD);
        expect_xfer(1, c0 + 7, 4, FLIT_TAIL);
        for (int k = 0; k < 9; k++) begin
            out_ready = (k >= 2 && k <= 4) ? 5'b11101 : 5'b11111;
            tick();
            if (k == 2) check_regs("t3_stall", 5'b00010, sel_of(1, 4), 1'b0);
        end
        out_ready = '1;
        check_drained("t3");

        // N's FIFO runs dry for two cycles; W waits on E meanwhile.
        c0 = cyc;
        expect_xfer(1, c0 + 1, 0, FLIT_HEADER);
        expect_xfer(1, c0 + 2, 0, FLIT_PAYLOAD);
        expect_xfer(1, c0 + 5, 0, FLIT_TAIL);
        expect_pkt(1, c0 + 7, 2, 2);
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                push_flit(0, FLIT_HEADER, RQ_E);
                push_flit(0, FLIT_PAYLOAD, RQ_E);
            end
            if (k == 3) push_pkt(2, RQ_E, 2);
            if (k == 5) push_flit(0, FLIT_TAIL, RQ_E);
            tick();
            if (k == 3) check_regs("t4_empty", 5'b00010, sel_of(1, 0), 1'b0);
        end
        check_drained("t4");

        // Multi-hot request, then an E->E U-turn; both pulse err and are never granted.
        c0 = cyc;
        push_flit(1, FLIT_HEADER, 5'b00011);
        err_q.push_back(c0 + 1);
        tick();
        fifo[1].delete();
        check_regs("t5_multihot", 5'b00000, '0, 1'b1);
        tick();
        check_regs("t5_multihot_clear", 5'b00000, '0, 1'b0);
        c0 = cyc;
        push_flit(1, FLIT_HEADER, RQ_E);
        err_q.push_back(c0 + 1);
        tick();
        fifo[1].delete();
        check_regs("t5_uturn", 5'b00000, '0, 1'b1);
        tick();
        check_regs("t5_uturn_clear", 5'b00000, '0, 1'b0);

        // L->L is a legal loopback.
        c0 = cyc;
        push_pkt(4, RQ_L, 2);
        expect_pkt(4, c0 + 1, 4, 2);
        tick();
        check_regs("t5_loopback", 5'b10000, sel_of(4, 4), 1'b0);
        repeat (3) tick();
        check_drained("t5");

        // Reset while S is mid-packet; afterwards ptr[S]=0 so W beats L.
        c0 = cyc;
        push_pkt(0, RQ_S, 4);
        expect_xfer(3, c0 + 1, 0, FLIT_HEADER);
        tick();
        tick();
        rst       = 1'b1;
        out_ready = 5'b10111;
        tick();
        rst       = 1'b0;
        out_ready = '1;
        for (int i = 0; i < NP; i++) fifo[i].delete();
        check_regs("t6_reset", 5'b00000, '0, 1'b0);
        push_pkt(2, RQ_S, 2);
        push_pkt(4, RQ_S, 2);
        expect_pkt(3, c0 + 4, 2, 2);
        expect_pkt(3, c0 + 7, 4, 2);
        repeat (7) tick();
        check_drained("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
